can_header_capture: RTL and testbench
=====================================

// Module: can_header_capture
// PURPOSE
// - Upstream stage of the frame-type decoder. Consumes sample-point strobes and sampled bus bits.
// - Detects SOF and removes stuff bits. Walks the arbitration and control fields of classical and FD frames, base and extended formats.
// - Presents ID, IDE, RTR/RRS, EDL (FDF), BRS, ESI and DLC, with a one-cycle hdr_valid strobe; the frame-type stage consumes EDL/RTR.
// - Holds the captured fields until the downstream frame logic signals frame_done.
// PARAMETERS
// STUFF_LEN  5   consecutive equal bits after which the next bit is a stuff bit
// IDLE_BITS  11  consecutive recessive sampled bits required in SYNC before SOF is accepted
// PORTS
// clk         in   1   system clock
// reset_n     in   1   asynchronous, active-low reset
// sp          in   1   sample-point strobe, one clk cycle wide
// rx_bit      in   1   sampled bus bit, valid when sp=1 (0 = dominant)
// frame_done  in   1   one-cycle pulse from downstream: frame ended, release header
// hdr_valid   out  1   one-cycle pulse: all header fields valid
// id          out  29  identifier; base ID in [28:18], ext ID in [17:0] (0 for base frames)
// ide         out  1   identifier extension bit
// rtr         out  1   raw RTR/RRS bit (bit after base ID, or after ext ID if ide=1)
// edl         out  1   FDF/EDL bit
// brs         out  1   bit-rate switch (0 when edl=0)
// esi         out  1   error-state indicator (0 when edl=0)
// dlc         out  4   data length code
// busy        out  1   1 in any state other than SYNC/IDLE
// stuff_err   out  1   one-cycle pulse: six equal consecutive bits seen
// BEHAVIOUR
// - Reset: all outputs 0. FSM enters SYNC with idle counter 0 and stuff counter 0.
// - Sampling: all state changes happen only on clk edges where sp=1, except frame_done (see below).
// - SYNC: count recessive sampled bits; a dominant bit clears the count. Count == IDLE_BITS -> IDLE.
// - IDLE: dominant bit = SOF -> BASE_ID, and busy=1. The stuff counter starts at 1 with last bit = 0.
// - Destuffing, SOF through the last DLC bit:
//   - Each data bit equal to the last bit increments the counter; a differing bit resets it to 1.
//   - Counter == STUFF_LEN: the next sampled bit is a stuff bit. It is not given to the field FSM.
//   - Stuff bit opposite to the last bit: counter := 1, last := stuff bit.
//   - Stuff bit equal to the last bit: stuff_err pulse, clear busy, go to SYNC (header discarded, no hdr_valid).
// - Field FSM (bit counts exclude stuff bits):
//   - BASE_ID: 11 bits, MSB first, into id[28:18].
//   - Then RTR_SRR: 1 bit, stored in rtr.
//   - Then IDE: 1 bit.
//     - ide=0 -> FDF.
//     - ide=1 -> EXT_ID: 18 bits into id[17:0], then RTR2: 1 bit overwrites rtr, then FDF.
//   - FDF: 1 bit -> edl.
//     - edl=1 -> RES (1 bit, ignored), BRS, ESI, then DLC.
//     - edl=0 -> R0 (1 bit, ignored), then DLC.
//   - DLC: 4 bits, MSB first.
// - hdr_valid: the cycle after the sp that carried the last DLC bit, hdr_valid=1 for exactly one clk; the FSM enters HOLD.
// - HOLD: fields stable, sp ignored. frame_done=1 -> IDLE next cycle and busy=0. Fields stay until the next SOF clears them.
// - frame_done outside HOLD is ignored. frame_done and sp in the same cycle in HOLD: go to IDLE, that sp bit is not treated as SOF.
// - Field outputs clear to 0 at SOF, so partial values are visible while busy but are meaningful only at hdr_valid.
// - reset_n low mid-frame: immediate return to reset values and SYNC; no pulses generated.
// - Counters: idle counter saturates at IDLE_BITS; field bit counter is 5 bits, reloaded on every field change.
// STRUCTURE
// - Package can_pkg holds:
//   - state enum hdr_state_e {SYNC, IDLE, BASE_ID, RTR_SRR, IDE, EXT_ID, RTR2, FDF, RES, R0, BRS, ESI, DLC, HOLD};
//   - field-length constants BASE_ID_LEN=11, EXT_ID_LEN=18, DLC_LEN=4;
//   - bit constants DOMINANT=1'b0, RECESSIVE=1'b1.
// - Sub-module can_destuffer (clk, reset_n, sp, rx_bit, enable -> data_sp, data_bit, stuff_err) holds the stuff counter and last bit.
//   - data_sp is sp gated off for stuff bits. The enable input is driven high from SOF through DLC.
// - Top level: field FSM, shift registers, SYNC counter and output registers.
// TESTING
// - Reset then 11 recessive, SOF, base ID 0x123, rtr=0, ide=0, fdf=0, r0, dlc=8 (stuffed correctly):
//   - hdr_valid once; id[28:18]=0x123, ide=0, rtr=0, edl=0, dlc=8.
// - Extended ID 0x1ABCDEF0, srr=1, ide=1, rtr=1, fdf=0, dlc=0:
//   - id=0x1ABCDEF0, ide=1, rtr=1, edl=0.
// - FD base ID 0x7F0, rrs=0, fdf=1, brs=1, esi=0, dlc=15:
//   - edl=1, brs=1, esi=0, dlc=15. ID bits 0x7F0 require stuff bits and are removed correctly.
// - Six dominant bits inside the base ID:
//   - stuff_err pulse, no hdr_valid, busy=0.
//   - The next SOF is ignored until 11 recessive bits have been seen.
// - HOLD with frame_done and sp=dominant in the same cycle:
//   - IDLE next cycle, no new frame started. The following dominant sp starts a frame.
// - reset_n asserted during EXT_ID: all outputs 0 immediately; a subsequent SOF is ignored before 11 recessive bits.

Source files
------------

// File: rtl/can_header_capture_pkg.sv
// Shared types and constants for the CAN header capture stage: field FSM states,
// field lengths, bus levels and the captured-header record.
package can_pkg;

    localparam int BASE_ID_LEN = 11;
    localparam int EXT_ID_LEN  = 18;
    localparam int DLC_LEN     = 4;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    typedef enum logic [3:0] {
        SYNC, IDLE, BASE_ID, RTR_SRR, IDE, EXT_ID, RTR2,
        FDF, RES, R0, BRS, ESI, DLC, HOLD
    } hdr_state_e;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic        edl;
        logic        brs;
        logic        esi;
        logic [3:0]  dlc;
    } hdr_fields_t;

    // True while the bit stream is inside the stuffed region (SOF .. last DLC bit).
    function automatic logic in_header(hdr_state_e s);
        return !(s inside {SYNC, IDLE, HOLD});
    endfunction

endpackage

// File: rtl/can_header_capture_if.sv
// Bit-stream input and decoded-header output bundle of can_header_capture.
// The master side drives sample strobes and frame_done; the slave side is the capture block.
interface can_header_capture_if;
    logic        sp;
    logic        rx_bit;
    logic        frame_done;
    logic        hdr_valid;
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic        edl;
    logic        brs;
    logic        esi;
    logic [3:0]  dlc;
    logic        busy;
    logic        stuff_err;

    modport master (
        output sp, rx_bit, frame_done,
        input  hdr_valid, id, ide, rtr, edl, brs, esi, dlc, busy, stuff_err
    );

    modport slave (
        input  sp, rx_bit, frame_done,
        output hdr_valid, id, ide, rtr, edl, brs, esi, dlc, busy, stuff_err
    );
endinterface

// File: rtl/can_header_capture_destuffer.sv
// Bit destuffer: tracks the run of equal bits and hides stuff bits from the field FSM.
// While disabled it sits preloaded as if SOF (one dominant bit) had just been seen.
module can_destuffer
    import can_pkg::*;
#(
    parameter int STUFF_LEN = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sp,
    input  logic rx_bit,
    input  logic enable,
    output logic data_sp,
    output logic data_bit,
    output logic stuff_err
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             stuff_slot;

    assign stuff_slot = (cnt_q == CNT_W'(STUFF_LEN));
    assign data_bit   = rx_bit;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        cnt_d     = cnt_q;
        last_d    = last_q;
        data_sp   = 1'b0;
        stuff_err = 1'b0;
        if (!enable) begin
            cnt_d  = CNT_W'(1);
            last_d = DOMINANT;
        end else if (sp) begin
            if (stuff_slot) begin
                if (rx_bit != last_q) begin
                    cnt_d  = CNT_W'(1);
                    last_d = rx_bit;
                end else begin
                    stuff_err = 1'b1;
                end
            end else begin
                data_sp = 1'b1;
                cnt_d   = (rx_bit == last_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
                last_d  = rx_bit;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= CNT_W'(1);
            last_q <= DOMINANT;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_header_capture.sv
// CAN header capture: bus-idle sync, SOF detection and the arbitration/control
// field walk for classical and FD frames, base and extended formats.
module can_header_capture
    import can_pkg::*;
#(
    parameter int STUFF_LEN = 5,
    parameter int IDLE_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    can_header_capture_if.slave  bus
);

    localparam int IDLE_W = $clog2(IDLE_BITS + 1);

    hdr_state_e       state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
    hdr_fields_t      fld_q, fld_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic             stuff_err_q, stuff_err_d;

    logic data_sp, data_bit, ds_stuff_err;

    can_destuffer #(.STUFF_LEN(STUFF_LEN)) u_destuffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .sp        (bus.sp),
        .rx_bit    (bus.rx_bit),
        .enable    (in_header(state_q)),
        .data_sp   (data_sp),
        .data_bit  (data_bit),
        .stuff_err (ds_stuff_err)
    );

    assign idle_inc = (idle_cnt_q == IDLE_W'(IDLE_BITS)) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        fld_d       = fld_q;
        hdr_valid_d = 1'b0;
        stuff_err_d = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (bus.sp) begin
                    if (bus.rx_bit == RECESSIVE) begin
                        idle_cnt_d = idle_inc;
                        if (idle_inc == IDLE_W'(IDLE_BITS)) state_d = IDLE;
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
            end
            IDLE: begin
                if (bus.sp && bus.rx_bit == DOMINANT) begin
                    state_d   = BASE_ID;
                    bit_cnt_d = '0;
                    fld_d     = '0;
                end
            end
            // sp is ignored here; only the downstream release moves us on.
            HOLD: begin
                if (bus.frame_done) state_d = IDLE;
            end
            default: begin
                if (ds_stuff_err) begin
                    state_d     = SYNC;
                    idle_cnt_d  = '0;
                    stuff_err_d = 1'b1;
                end else if (data_sp) begin
                    bit_cnt_d = '0;
                    unique case (state_q)
                        BASE_ID: begin
                            fld_d.id[28:18] = {fld_q.id[27:18], data_bit};
                            if (bit_cnt_q == 5'(BASE_ID_LEN - 1)) state_d = RTR_SRR;
                            else bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                        RTR_SRR: begin
                            fld_d.rtr = data_bit;
                            state_d   = IDE;
                        end
                        IDE: begin
                            fld_d.ide = data_bit;
                            state_d   = data_bit ? EXT_ID : FDF;
                        end
                        EXT_ID: begin
                            fld_d.id[17:0] = {fld_q.id[16:0], data_bit};
                            if (bit_cnt_q == 5'(EXT_ID_LEN - 1)) state_d = RTR2;
                            else bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                        RTR2: begin
                            fld_d.rtr = data_bit;
                            state_d   = FDF;
                        end
                        FDF: begin
                            fld_d.edl = data_bit;
                            state_d   = data_bit ? RES : R0;
                        end
                        RES:     state_d = BRS;
                        R0:      state_d = DLC;
                        BRS: begin
                            fld_d.brs = data_bit;
                            state_d   = ESI;
                        end
                        ESI: begin
                            fld_d.esi = data_bit;
                            state_d   = DLC;
                        end
                        DLC: begin
                            fld_d.dlc = {fld_q.dlc[2:0], data_bit};
                            if (bit_cnt_q == 5'(DLC_LEN - 1)) begin
                                state_d     = HOLD;
                                hdr_valid_d = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 5'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SYNC;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            fld_q       <= '0;
            hdr_valid_q <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            fld_q       <= fld_d;
            hdr_valid_q <= hdr_valid_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    assign bus.hdr_valid = hdr_valid_q;
    assign bus.stuff_err = stuff_err_q;
    assign bus.id        = fld_q.id;
    assign bus.ide       = fld_q.ide;
    assign bus.rtr       = fld_q.rtr;
    assign bus.edl       = fld_q.edl;
    assign bus.brs       = fld_q.brs;
    assign bus.esi       = fld_q.esi;
    assign bus.dlc       = fld_q.dlc;
    assign bus.busy      = !(state_q inside {SYNC, IDLE});

endmodule

// File: tb/tb_can_header_capture.sv
// Randomised bench for can_header_capture: frames are built bit-by-bit from header
// fields, stuffed, and the expected events are scored by an independent monitor.
module tb_can_header_capture;
    import can_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    can_header_capture_if bus ();

    can_header_capture #(.STUFF_LEN(5), .IDLE_BITS(11)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [28:0] id;
        bit        ide, srr, rtr, edl, res, brs, esi;
        bit [3:0]  dlc;
    } frame_t;

    typedef struct {
        bit        is_err;
        bit [28:0] id;
        bit        ide, rtr, edl, brs, esi;
        bit [3:0]  dlc;
    } exp_t;

    exp_t exp_q[$];
    bit   tx_bits[$];
    int   tx_raw_idx[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Wire-level bit sequence of the header, then stuffed after every run of five.
    task automatic build(input frame_t f);
        bit raw[$];
        bit last;
        int run;
        raw.push_back(1'b0);
        for (int i = 28; i >= 18; i--) raw.push_back(f.id[i]);
        if (f.ide) begin
            raw.push_back(f.srr);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(f.id[i]);
            raw.push_back(f.rtr);
        end else begin
            raw.push_back(f.rtr);
            raw.push_back(1'b0);
        end
        raw.push_back(f.edl);
        raw.push_back(f.res);
        if (f.edl) begin
            raw.push_back(f.brs);
            raw.push_back(f.esi);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(f.dlc[i]);
        tx_bits.delete();
        tx_raw_idx.delete();
        run  = 0;
        last = 1'b0;
        foreach (raw[i]) begin
            tx_bits.push_back(raw[i]);
            tx_raw_idx.push_back(i);
            if (i > 0 && raw[i] == last) run++;
            else run = 1;
            last = raw[i];
            if (run == 5) begin
                tx_bits.push_back(~last);
                tx_raw_idx.push_back(-1);
                last = ~last;
                run  = 1;
            end
        end
    endtask

    function automatic exp_t expect_of(input frame_t f);
        exp_t e;
        e.is_err = 1'b0;
        e.id     = f.ide ? f.id : {f.id[28:18], 18'd0};
        e.ide    = f.ide;
        e.rtr    = f.rtr;
        e.edl    = f.edl;
        e.brs    = f.edl ? f.brs : 1'b0;
        e.esi    = f.edl ? f.esi : 1'b0;
        e.dlc    = f.dlc;
        return e;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.id  = 29'($urandom);
        f.ide = 1'($urandom_range(0, 1));
        f.srr = 1'($urandom_range(0, 1));
        f.rtr = 1'($urandom_range(0, 1));
        f.edl = 1'($urandom_range(0, 1));
        f.res = 1'($urandom_range(0, 1));
        f.brs = 1'($urandom_range(0, 1));
        f.esi = 1'($urandom_range(0, 1));
        f.dlc = 4'($urandom_range(0, 15));
        return f;
    endfunction

    task automatic send_bit(input bit b);
        @(negedge clk);
        bus.sp     = 1'b1;
        bus.rx_bit = b;
        @(negedge clk);
        bus.sp     = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        repeat (n) send_bit(RECESSIVE);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Send one header and leave the DUT in HOLD with a few ignored bus bits.
    task automatic send_header(input frame_t f);
        build(f);
        last_exp = expect_of(f);
        exp_q.push_back(last_exp);
        foreach (tx_bits[k]) send_bit(tx_bits[k]);
        wait_drain("hdr_timeout");
        repeat ($urandom_range(0, 4)) send_bit(1'($urandom_range(0, 1)));
        check("busy_in_hold", 32'(bus.busy), 32'd1);
    endtask

    task automatic release_header();
        @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("id_held", 32'(bus.id), 32'(last_exp.id));
        check("dlc_held", 32'(bus.dlc), 32'(last_exp.dlc));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {bus.hdr_valid, bus.ide, bus.rtr, bus.edl, bus.brs,
                               bus.esi, bus.busy, bus.stuff_err, bus.dlc}, 32'd0);
        check({name, "_id"}, 32'(bus.id), 32'd0);
    endtask

    // Scoreboard: every hdr_valid / stuff_err pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && (bus.hdr_valid || bus.stuff_err)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: hdr_valid=%0b stuff_err=%0b, expected no pulse",
                         bus.hdr_valid, bus.stuff_err);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'({bus.hdr_valid, bus.stuff_err}), e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check("id", 32'(bus.id), 32'(e.id));
                    check("ide", 32'(bus.ide), 32'(e.ide));
                    check("rtr", 32'(bus.rtr), 32'(e.rtr));
                    check("edl", 32'(bus.edl), 32'(e.edl));
                    check("brs", 32'(bus.brs), 32'(e.brs));
                    check("esi", 32'(bus.esi), 32'(e.esi));
                    check("dlc", 32'(bus.dlc), 32'(e.dlc));
                end else begin
                    check("busy_at_err", 32'(bus.busy), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        frame_t f;
        exp_t   err;
        bus.sp         = 1'b0;
        bus.rx_bit     = RECESSIVE;
        bus.frame_done = 1'b0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // SOF before bus idle is recognised must be ignored.
        send_bit(DOMINANT);
        check("sof_before_sync", 32'(bus.busy), 32'd0);
        send_idle(11);

        f = '{id: {11'h123, 18'd0}, ide: 0, srr: 0, rtr: 0, edl: 0, res: 0, brs: 0, esi: 0, dlc: 4'd8};
        send_header(f);
        release_header();

        f = '{id: 29'h1ABCDEF0, ide: 1, srr: 1, rtr: 1, edl: 0, res: 0, brs: 0, esi: 0, dlc: 4'd0};
        send_header(f);
        release_header();

        f = '{id: {11'h7F0, 18'd0}, ide: 0, srr: 0, rtr: 0, edl: 1, res: 0, brs: 1, esi: 0, dlc: 4'd15};
        send_header(f);
        release_header();

        // Six dominant bits: SOF plus five more; the fifth after SOF is a bad stuff bit.
        err = '{is_err: 1'b1, default: '0};
        exp_q.push_back(err);
        repeat (6) send_bit(DOMINANT);
        wait_drain("stuff_err_timeout");
        check("busy_after_stuff_err", 32'(bus.busy), 32'd0);
        send_idle(10);
        send_bit(DOMINANT);
        check("sof_after_10_idle", 32'(bus.busy), 32'd0);
        send_idle(11);

        // frame_done and a dominant sp together in HOLD: release only, no SOF.
        send_header(rand_frame());
        @(negedge clk);
        bus.sp         = 1'b1;
        bus.rx_bit     = DOMINANT;
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.sp         = 1'b0;
        bus.frame_done = 1'b0;
        check("done_sp_to_idle", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("done_sp_no_frame", 32'(bus.busy), 32'd0);
        send_header(rand_frame());
        release_header();

        // Reset asserted in the middle of the extended ID.
        f = '{id: 29'h15A5A5A5, ide: 1, srr: 1, rtr: 0, edl: 0, res: 0, brs: 0, esi: 0, dlc: 4'd3};
        build(f);
        foreach (tx_bits[k]) begin
            if (tx_raw_idx[k] > 19) break;
            send_bit(tx_bits[k]);
        end
        check("busy_in_ext_id", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        @(negedge clk);
        reset_n = 1'b1;
        send_bit(DOMINANT);
        check("sof_after_reset", 32'(bus.busy), 32'd0);
        send_idle(11);

        for (int n = 0; n < 40; n++) begin
            send_header(rand_frame());
            release_header();
            if ($urandom_range(0, 3) == 0) send_idle($urandom_range(1, 3));
        end

        wait_drain("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
